// File: rtl/exc_epc_stack.sv
// exc_epc_stack: prioritised exception arbiter with a nested EPC/cause stack.
// Redirects taken requests to vectored handlers and unwinds them on ERET.
module exc_epc_stack #(
  parameter int              WIDTH        = 32,
  parameter int              NUM_SRC      = 4,
  parameter int              DEPTH        = 2,
  parameter logic [WIDTH-1:0] HANDLER_BASE = 32'h8000_0004,
  parameter logic [WIDTH-1:0] VEC_STRIDE   = 32'h0000_0010,
  parameter int              CW           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int              LW           = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] exc_req_i,
  input  logic [WIDTH-1:0]   epc_i,
  input  logic               eret_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  output logic               take_o,
  output logic [NUM_SRC-1:0] ack_o,
  output logic [WIDTH-1:0]   handler_pc_o,
  output logic               ret_o,
  output logic [WIDTH-1:0]   epc_o,
  output logic [CW-1:0]      cause_o,
  output logic [LW-1:0]      level_o,
  output logic [NUM_SRC-1:0] mask_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  logic [WIDTH-1:0]   epc_q [DEPTH];
  logic [WIDTH-1:0]   epc_d [DEPTH];
  logic [CW-1:0]      cse_q [DEPTH];
  logic [CW-1:0]      cse_d [DEPTH];
  logic [LW-1:0]      lvl_q, lvl_d;
  logic               pop_q, pop_d;
  logic               take_q, take_d;
  logic               ret_q, ret_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [WIDTH-1:0]   hpc_q, hpc_d;

  logic [WIDTH-1:0]   top_epc;
  logic [CW-1:0]      top_cse;
  logic [NUM_SRC-1:0] cand;
  logic               win_vld;
  logic [CW-1:0]      win;
  logic               qual;

  // Top-of-stack view; zero when the stack is empty.
  always_comb begin
    top_epc = '0;
    top_cse = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lvl_q == LW'(i + 1)) begin
        top_epc = epc_q[i];
        top_cse = cse_q[i];
      end
    end
  end

  // Pick the lowest-index enabled request and test it for preemption.
  always_comb begin
    cand    = exc_req_i & mask_q;
    win_vld = 1'b0;
    win     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win     = CW'(i);
      end
    end
    qual = win_vld && ((lvl_q == '0) || (win < top_cse));
  end

  // Next state: a pending pop first, then ERET, then a new exception.
  always_comb begin
    epc_d  = epc_q;
    cse_d  = cse_q;
    lvl_d  = lvl_q;
    pop_d  = 1'b0;
    take_d = 1'b0;
    ret_d  = 1'b0;
    ack_d  = '0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    hpc_d  = hpc_q;
    mask_d = mask_we_i ? mask_wdata_i : mask_q;
    if (pop_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (lvl_q == LW'(i + 1)) begin
          epc_d[i] = '0;
          cse_d[i] = '0;
        end
      end
      lvl_d = lvl_q - LW'(1);
    end else if (eret_i) begin
      if (lvl_q != '0) begin
        ret_d = 1'b1;
        pop_d = 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end else if (qual) begin
      if (lvl_q < LW'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (lvl_q == LW'(i)) begin
            epc_d[i] = epc_i;
            cse_d[i] = win;
          end
        end
        lvl_d  = lvl_q + LW'(1);
        take_d = 1'b1;
        ack_d  = NUM_SRC'(1) << win;
        hpc_d  = HANDLER_BASE + WIDTH'(win) * VEC_STRIDE;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers; reset empties the stack and re-enables all sources.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        epc_q[i] <= '0;
        cse_q[i] <= '0;
      end
      lvl_q  <= '0;
      pop_q  <= 1'b0;
      take_q <= 1'b0;
      ret_q  <= 1'b0;
      ack_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      hpc_q  <= '0;
      mask_q <= '1;
    end else begin
      epc_q  <= epc_d;
      cse_q  <= cse_d;
      lvl_q  <= lvl_d;
      pop_q  <= pop_d;
      take_q <= take_d;
      ret_q  <= ret_d;
      ack_q  <= ack_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      hpc_q  <= hpc_d;
      mask_q <= mask_d;
    end
  end

  assign take_o       = take_q;
  assign ack_o        = ack_q;
  assign handler_pc_o = hpc_q;
  assign ret_o        = ret_q;
  assign epc_o        = top_epc;
  assign cause_o      = top_cse;
  assign level_o      = lvl_q;
  assign mask_o       = mask_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;

endmodule

// File: tb/tb_exc_epc_stack.sv
// tb_exc_epc_stack: directed vector table, async reset check and
// randomized traffic against a queue-based reference model.
module tb_exc_epc_stack;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic        take;
    logic [3:0]  ack;
    logic [31:0] hpc;
    logic        ret;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [1:0]  level;
    logic [3:0]  mask;
    logic        ovf;
    logic        unf;
  } out_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] epc;
    logic        eret;
    logic        mwe;
    logic [3:0]  mwd;
    out_t        exp;
  } vec_t;

  typedef struct {
    logic [31:0] epc;
    logic [1:0]  cause;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [3:0]  exc_req_i;
  logic [31:0] epc_i;
  logic        eret_i;
  logic        mask_we_i;
  logic [3:0]  mask_wdata_i;
  logic        take_o;
  logic [3:0]  ack_o;
  logic [31:0] handler_pc_o;
  logic        ret_o;
  logic [31:0] epc_o;
  logic [1:0]  cause_o;
  logic [1:0]  level_o;
  logic [3:0]  mask_o;
  logic        overflow_o;
  logic        underflow_o;

  int n_cmp = 0;
  int n_mis = 0;

  vec_t tbl[$];
  ent_t stk[$];
  logic m_pop;
  out_t m;
  out_t rst_exp;

  exc_epc_stack dut (
    .clk          (clk),
    .reset        (reset),
    .exc_req_i    (exc_req_i),
    .epc_i        (epc_i),
    .eret_i       (eret_i),
    .mask_we_i    (mask_we_i),
    .mask_wdata_i (mask_wdata_i),
    .take_o       (take_o),
    .ack_o        (ack_o),
    .handler_pc_o (handler_pc_o),
    .ret_o        (ret_o),
    .epc_o        (epc_o),
    .cause_o      (cause_o),
    .level_o      (level_o),
    .mask_o       (mask_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input out_t e);
    chk({tag, ".take"},  32'(take_o),       32'(e.take));
    chk({tag, ".ack"},   32'(ack_o),        32'(e.ack));
    chk({tag, ".hpc"},   handler_pc_o,      e.hpc);
    chk({tag, ".ret"},   32'(ret_o),        32'(e.ret));
    chk({tag, ".epc"},   epc_o,             e.epc);
    chk({tag, ".cause"}, 32'(cause_o),      32'(e.cause));
    chk({tag, ".level"}, 32'(level_o),      32'(e.level));
    chk({tag, ".mask"},  32'(mask_o),       32'(e.mask));
    chk({tag, ".ovf"},   32'(overflow_o),   32'(e.ovf));
    chk({tag, ".unf"},   32'(underflow_o),  32'(e.unf));
  endtask

  task automatic add(input logic [3:0] req, input logic [31:0] epc,
                     input logic eret, input logic mwe, input logic [3:0] mwd,
                     input logic tk, input logic [3:0] ak,
                     input logic [31:0] hpc, input logic rt,
                     input logic [31:0] ep, input logic [1:0] cs,
                     input logic [1:0] lv, input logic [3:0] mk,
                     input logic ov, input logic un);
    vec_t v;
    v.req  = req;
    v.epc  = epc;
    v.eret = eret;
    v.mwe  = mwe;
    v.mwd  = mwd;
    v.exp  = '{tk, ak, hpc, rt, ep, cs, lv, mk, ov, un};
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    stk.delete();
    m_pop = 1'b0;
    m = rst_exp;
  endtask

  // Reference: a return takes effect one cycle after it is reported,
  // returns outrank new requests, and a pending pop blocks arbitration.
  task automatic model_step(input logic [3:0] req, input logic [31:0] epc,
                            input logic eret, input logic mwe,
                            input logic [3:0] mwd);
    int w;
    logic [3:0] cand;
    ent_t e;
    m.take = 1'b0;
    m.ack  = '0;
    m.ret  = 1'b0;
    if (m_pop) begin
      void'(stk.pop_back());
      m_pop = 1'b0;
    end else if (eret) begin
      if (stk.size() > 0) begin
        m.ret = 1'b1;
        m_pop = 1'b1;
      end else begin
        m.unf = 1'b1;
      end
    end else begin
      cand = req & m.mask;
      w = -1;
      for (int i = 3; i >= 0; i--) if (cand[i]) w = i;
      if (w >= 0 && (stk.size() == 0 || w < int'(stk[$].cause))) begin
        if (stk.size() < DEPTH) begin
          e.epc   = epc;
          e.cause = 2'(w);
          stk.push_back(e);
          m.take = 1'b1;
          m.ack  = 4'(1 << w);
          m.hpc  = 32'h8000_0004 + 32'(w) * 32'h10;
        end else begin
          m.ovf = 1'b1;
        end
      end
    end
    if (mwe) m.mask = mwd;
    m.level = 2'(stk.size());
    m.epc   = (stk.size() > 0) ? stk[$].epc : 32'h0;
    m.cause = (stk.size() > 0) ? stk[$].cause : 2'd0;
  endtask

  initial begin
    rst_exp = '{1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 2'd0, 2'd0, 4'hF, 1'b0, 1'b0};
    reset = 1'b0;
    exc_req_i = '0;
    epc_i = '0;
    eret_i = 1'b0;
    mask_we_i = 1'b0;
    mask_wdata_i = '0;

    //   req   epc           er we wd  | tk ak  hpc           rt epc           cs lv mk   ov un
    add(4'h0, 32'h0,        0, 0, 4'h0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 0, 4'hF, 0, 0);
    add(4'h0, 32'h0,        1, 0, 4'h0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 0, 4'hF, 0, 1);
    add(4'h4, 32'h0040_0010, 0, 0, 4'h0, 1, 4'h4, 32'h8000_0024, 0, 32'h0040_0010, 2, 1, 4'hF, 0, 1);
    add(4'h8, 32'h0,        0, 0, 4'h0, 0, 4'h0, 32'h8000_0024, 0, 32'h0040_0010, 2, 1, 4'hF, 0, 1);
    add(4'h1, 32'h8000_0030, 0, 0, 4'h0, 1, 4'h1, 32'h8000_0004, 0, 32'h8000_0030, 0, 2, 4'hF, 0, 1);
    add(4'h0, 32'h0,        1, 0, 4'h0, 0, 4'h0, 32'h8000_0004, 1, 32'h8000_0030, 0, 2, 4'hF, 0, 1);
    add(4'h0, 32'h0,        0, 0, 4'h0, 0, 4'h0, 32'h8000_0004, 0, 32'h0040_0010, 2, 1, 4'hF, 0, 1);
    add(4'h0, 32'h0,        1, 0, 4'h0, 0, 4'h0, 32'h8000_0004, 1, 32'h0040_0010, 2, 1, 4'hF, 0, 1);
    add(4'h0, 32'h0,        0, 0, 4'h0, 0, 4'h0, 32'h8000_0004, 0, 32'h0,        0, 0, 4'hF, 0, 1);
    add(4'h4, 32'h100,      0, 0, 4'h0, 1, 4'h4, 32'h8000_0024, 0, 32'h100,      2, 1, 4'hF, 0, 1);
    add(4'h2, 32'h200,      0, 0, 4'h0, 1, 4'h2, 32'h8000_0014, 0, 32'h200,      1, 2, 4'hF, 0, 1);
    add(4'h1, 32'h300,      0, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 0, 32'h200,      1, 2, 4'hF, 1, 1);
    add(4'h0, 32'h0,        1, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 1, 32'h200,      1, 2, 4'hF, 1, 1);
    add(4'h0, 32'h0,        0, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 0, 32'h100,      2, 1, 4'hF, 1, 1);
    add(4'h2, 32'h0,        1, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 1, 32'h100,      2, 1, 4'hF, 1, 1);
    add(4'h2, 32'h0,        0, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 0, 32'h0,        0, 0, 4'hF, 1, 1);
    add(4'h2, 32'h400,      0, 0, 4'h0, 1, 4'h2, 32'h8000_0014, 0, 32'h400,      1, 1, 4'hF, 1, 1);
    add(4'h0, 32'h0,        1, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 1, 32'h400,      1, 1, 4'hF, 1, 1);
    add(4'h0, 32'h0,        0, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 0, 32'h0,        0, 0, 4'hF, 1, 1);
    add(4'h0, 32'h0,        0, 1, 4'hE, 0, 4'h0, 32'h8000_0014, 0, 32'h0,        0, 0, 4'hE, 1, 1);
    add(4'h1, 32'h500,      0, 0, 4'h0, 0, 4'h0, 32'h8000_0014, 0, 32'h0,        0, 0, 4'hE, 1, 1);
    add(4'h2, 32'h600,      0, 0, 4'h0, 1, 4'h2, 32'h8000_0014, 0, 32'h600,      1, 1, 4'hE, 1, 1);

    #12;
    check_all("in_reset", rst_exp);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) begin
      exc_req_i    = tbl[k].req;
      epc_i        = tbl[k].epc;
      eret_i       = tbl[k].eret;
      mask_we_i    = tbl[k].mwe;
      mask_wdata_i = tbl[k].mwd;
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", k), tbl[k].exp);
      @(negedge clk);
    end

    exc_req_i = '0;
    eret_i    = 1'b0;
    mask_we_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("mid_reset", rst_exp);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    model_step(4'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    check_all("post_reset", m);
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  r;
      logic [31:0] e;
      logic        er, we;
      logic [3:0]  wd;
      r  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      e  = $urandom;
      er = ($urandom_range(0, 7) == 0);
      we = ($urandom_range(0, 15) == 0);
      wd = 4'($urandom_range(0, 15));
      if (i % 500 == 499) begin
        reset = 1'b0;
        #1;
        check_all($sformatf("rnd_rst%0d", i), rst_exp);
        reset = 1'b1;
        model_reset();
      end
      exc_req_i    = r;
      epc_i        = e;
      eret_i       = er;
      mask_we_i    = we;
      mask_wdata_i = wd;
      model_step(r, e, er, we, wd);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", i), m);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/exc_epc_stack.md
Name: exc_epc_stack

Overview:
- Parametrised successor to the single exception-PC register in the multi-cycle MIPS core.
- Arbitrates NUM_SRC prioritised exception/interrupt requests and saves the return PC and cause on a DEPTH-entry nesting stack.
- Issues a registered handler-redirect pulse and restores state on ERET.
- Sits between the control FSM (requests, ERET) and the PC-select mux (handler_pc_o, epc_o).

Parameters:
- WIDTH, 32, PC width.
- NUM_SRC, 4, number of request sources; index 0 is highest priority.
- DEPTH, 2, maximum nesting levels (1 or more).
- HANDLER_BASE, 32'h8000_0004, handler address for source 0.
- VEC_STRIDE, 32'h0000_0010, address step between handler entries.
- CW, $clog2(NUM_SRC) (minimum 1), cause field width, derived.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exc_req_i  in  NUM_SRC  level request per source; held by requester until acked.
- epc_i  in  WIDTH  PC to save if the request is taken this edge.
- eret_i  in  1  return-from-exception strobe, one cycle.
- mask_we_i  in  1  mask register write enable.
- mask_wdata_i  in  NUM_SRC  new mask; bit=1 enables that source.
- take_o  out  1  one-cycle pulse: exception taken; also acks the requester.
- ack_o  out  NUM_SRC  one-hot copy of the taken source, valid while take_o=1.
- handler_pc_o  out  WIDTH  HANDLER_BASE + cause*VEC_STRIDE, valid while take_o=1.
- ret_o  out  1  one-cycle pulse: ERET accepted; epc_o holds the return PC this cycle.
- epc_o  out  WIDTH  top-of-stack EPC; 0 when empty.
- cause_o  out  CW  top-of-stack cause; 0 when empty.
- level_o  out  $clog2(DEPTH+1)  current nesting depth.
- mask_o  out  NUM_SRC  current mask.
- overflow_o  out  1  sticky: a qualifying request arrived at full depth.
- underflow_o  out  1  sticky: ERET arrived at depth 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stack entries, level, take_o, ack_o, ret_o, overflow_o and underflow_o are cleared to 0.
  - handler_pc_o and epc_o are 0. mask_o is all ones.
- All state updates on the rising clk edge. All outputs are registered or derived from registers.
- Qualification:
  - Candidate = exc_req_i & mask, evaluated against mask as held before this edge.
  - Winner = lowest-index set candidate bit.
  - At level 0, any winner qualifies.
  - At level>0, the winner qualifies only if its index < cause_o (strict preemption). Equal or lower priority waits.
- Take, when a winner qualifies, eret_i=0 and level<DEPTH:
  - Push {epc_i, winner}; level+1.
  - Next cycle: take_o=1, ack_o=onehot(winner), handler_pc_o updated. Latency is 1 cycle from the sampling edge.
- Full, when a winner qualifies and level==DEPTH:
  - No push. overflow_o is set and stays set until reset.
  - The request is left pending.
- ERET, when eret_i=1 and level>0:
  - Next cycle: ret_o=1 and epc_o/cause_o show the popped entry.
  - The cycle after that: the pop is visible (level-1). The vacated entry is cleared to 0.
  - ERET at level 0: no pop, no ret_o, underflow_o set (sticky).
- Simultaneous ERET and qualifying request: ERET wins. The request is re-evaluated on later edges against the new top.
- mask write:
  - mask <= mask_wdata_i at the edge.
  - The new mask applies from the next evaluation. It never affects entries already on the stack.
- A request still high in the take_o cycle does not re-trigger, because its index equals cause_o.
- handler_pc_o arithmetic is modulo 2^WIDTH. It holds its last value when take_o=0.
- Reset mid-handler discards the whole stack; no ret_o is generated.

Test Plan:
- Reset then release: epc_o=0, cause_o=0, level_o=0, mask_o=4'hF, flags 0; eret_i pulse -> underflow_o=1, ret_o stays 0.
- exc_req_i=4'b0100, epc_i=32'h0040_0010 -> next cycle take_o=1, ack_o=4'b0100, handler_pc_o=32'h8000_0024, level_o=1, cause_o=2; eret_i -> ret_o=1, epc_o=32'h0040_0010, then level_o=0.
- In the src2 handler, raise src3 -> no take; raise src0 with epc_i=32'h8000_0030 -> take, level_o=2, handler_pc_o=32'h8000_0004; ERET twice -> epc_o 32'h8000_0030, then 32'h0040_0010.
- At level 2, with cause_o=1 (src1 preempting src2), raise src0 -> no take, overflow_o=1 and stays set through later ERETs until reset.
- Same edge: eret_i=1 with src1 requesting at level 1 -> ret_o first, then take_o on the following evaluation with level 0->1.
- mask_wdata_i=4'b1110, then request src0 -> ignored; request src1 -> taken. Assert reset while level_o=1 -> all outputs return to reset values at once.
